// File: rtl/pipe_source.sv
// Valid/ready stream source: emits num_items beats of an arithmetic sequence
// (start, step) with an optional idle gap between beats.
//
// state | meaning
// IDLE  | waiting for start_i, config not yet captured
// SEND  | beat presented, waiting for pipe_out_rdy
// GAP   | idle cycles between beats, gap counter running
// DONE  | one-cycle end-of-run pulse
module pipe_source #(
  parameter int DATA_W = 5,
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  num_items_i,
  input  logic [DATA_W-1:0] start_val_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [GAP_W-1:0]  gap_i,
  output logic [DATA_W-1:0] output_val,
  output logic              pipe_out_valid,
  input  logic              pipe_out_rdy,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [CNT_W-1:0]  sent_count_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic              valid_q, valid_d;
  logic              aborted_q, aborted_d;

  logic xfer;
  logic last_beat;

  assign xfer = valid_q & pipe_out_rdy;
  // Compared against num-1 so a full-scale num_items never needs a wider counter.
  assign last_beat = (cnt_q == num_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    step_d    = step_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    valid_d   = valid_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start_i) begin
          num_d     = num_items_i;
          val_d     = start_val_i;
          step_d    = step_i;
          gap_d     = gap_i;
          cnt_d     = '0;
          aborted_d = 1'b0;
          if (num_items_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = SEND;
            valid_d = 1'b1;
          end
        end
      end
      SEND: begin
        // Abort only takes effect on a transfer edge so a presented beat is never withdrawn.
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          val_d = val_q + step_q;
          if (last_beat) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else if (abort_i) begin
            state_d   = DONE;
            valid_d   = 1'b0;
            aborted_d = 1'b1;
          end else if (gap_q == '0) begin
            valid_d = 1'b1;
          end else begin
            state_d = GAP;
            valid_d = 1'b0;
            gcnt_d  = gap_q;
          end
        end
      end
      GAP: begin
        if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          valid_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      val_q     <= '0;
      step_q    <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      valid_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      step_q    <= step_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      valid_q   <= valid_d;
      aborted_q <= aborted_d;
    end
  end

  assign output_val     = val_q;
  assign pipe_out_valid = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign aborted_o      = aborted_q;
  assign sent_count_o   = cnt_q;

endmodule

// File: tb/tb_pipe_source.sv
// Bench for pipe_source: run-level reference model checked every cycle,
// plus directed runs with literal expectations on the transferred beats.
module tb_pipe_source;
  localparam int DATA_W = 5;
  localparam int CNT_W  = 8;
  localparam int GAP_W  = 4;
  localparam int VMASK  = (1 << DATA_W) - 1;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [CNT_W-1:0]  num_items_i = '0;
  logic [DATA_W-1:0] start_val_i = '0;
  logic [DATA_W-1:0] step_i = '0;
  logic [GAP_W-1:0]  gap_i = '0;
  logic [DATA_W-1:0] output_val;
  logic              pipe_out_valid;
  logic              pipe_out_rdy = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [CNT_W-1:0]  sent_count_o;

  pipe_source #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .num_items_i(num_items_i), .start_val_i(start_val_i), .step_i(step_i),
    .gap_i(gap_i), .output_val(output_val), .pipe_out_valid(pipe_out_valid),
    .pipe_out_rdy(pipe_out_rdy), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .sent_count_o(sent_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int base_done = 0;
  int start_cyc = 0;
  logic [DATA_W-1:0] log_q[$];
  int xcyc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Run-level model: a run is (num, start, step, gap); beat k carries start+k*step.
  bit m_run, m_done, m_aborted;
  int m_num, m_sv, m_step, m_gap, m_sent, m_idle;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_run = 0; m_done = 0; m_aborted = 0;
      m_num = 0; m_sv = 0; m_step = 0; m_gap = 0; m_sent = 0; m_idle = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start_i) begin
        m_num = int'(num_items_i); m_sv = int'(start_val_i);
        m_step = int'(step_i); m_gap = int'(gap_i);
        m_sent = 0; m_aborted = 0; m_idle = 0;
        if (m_num == 0) m_done = 1;
        else m_run = 1;
      end
    end else if (m_idle == 0) begin
      if (pipe_out_rdy) begin
        m_sent++;
        if (m_sent == m_num) begin
          m_run = 0; m_done = 1;
        end else if (abort_i) begin
          m_run = 0; m_done = 1; m_aborted = 1;
        end else begin
          m_idle = m_gap;
        end
      end
    end else if (abort_i) begin
      m_run = 0; m_done = 1; m_aborted = 1;
    end else begin
      m_idle--;
    end
  end

  logic              p_valid = 1'b0;
  logic              p_xfer = 1'b0;
  logic [DATA_W-1:0] p_val = '0;

  always @(negedge clk_i) begin
    if (reset_ni) begin
      chk("valid", int'(pipe_out_valid), int'(m_run && m_idle == 0));
      chk("busy", int'(busy_o), int'(m_run || m_done));
      chk("done", int'(done_o), int'(m_done));
      chk("sent_count", int'(sent_count_o), m_sent);
      chk("aborted", int'(aborted_o), int'(m_aborted));
      if (m_run && m_idle == 0)
        chk("value", int'(output_val), (m_sv + m_sent * m_step) & VMASK);
      if (p_valid && !p_xfer) begin
        chk("hold_valid", int'(pipe_out_valid), 1);
        chk("hold_value", int'(output_val), int'(p_val));
      end
      if (pipe_out_valid && pipe_out_rdy) begin
        log_q.push_back(output_val);
        xcyc_q.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      p_valid = pipe_out_valid;
      p_xfer  = pipe_out_valid && pipe_out_rdy;
      p_val   = output_val;
    end else begin
      p_valid = 1'b0;
    end
  end

  task automatic go(input int num, input int sv, input int st, input int g);
    @(posedge clk_i); #1;
    num_items_i = CNT_W'(num);
    start_val_i = DATA_W'(sv);
    step_i      = DATA_W'(st);
    gap_i       = GAP_W'(g);
    start_i     = 1'b1;
    start_cyc   = cyc;
    base_done   = done_cnt;
    log_q.delete();
    xcyc_q.delete();
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == base_done && k < budget) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("done_seen", done_cnt - base_done, 1);
  endtask

  task automatic chk_seq(input string name, input int sv, input int st, input int n);
    chk({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk({name, "_beat"}, int'(log_q[i]), (sv + i * st) & VMASK);
  endtask

  initial begin
    #1;
    chk("rst_valid", int'(pipe_out_valid), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_val", int'(output_val), 0);
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_count", int'(sent_count_o), 0);
    chk("idle_done", int'(done_o), 0);

    pipe_out_rdy = 1'b1;
    go(4, 3, 1, 0);
    wait_done(50);
    chk_seq("basic", 3, 1, 4);
    if (xcyc_q.size() == 4) begin
      chk("basic_first_lat", xcyc_q[0] - start_cyc, 1);
      chk("basic_done_lat", done_cyc - xcyc_q[3], 1);
    end
    chk("basic_sent", int'(sent_count_o), 4);

    go(3, 30, 3, 0);
    wait_done(50);
    chk("wrap_b1", int'(log_q.size() > 1 ? log_q[1] : '1), 1);
    chk_seq("wrap", 30, 3, 3);

    go(3, 0, 1, 2);
    wait_done(50);
    chk_seq("gap", 0, 1, 3);
    if (xcyc_q.size() == 3) chk("gap_span", xcyc_q[2] - xcyc_q[0] + 1, 7);

    pipe_out_rdy = 1'b0;
    go(2, 10, 5, 0);
    repeat (5) begin @(posedge clk_i); #1; end
    pipe_out_rdy = 1'b1;
    wait_done(50);
    chk_seq("stall", 10, 5, 2);

    pipe_out_rdy = 1'b0;
    go(3, 7, 1, 0);
    repeat (2) begin @(posedge clk_i); #1; end
    abort_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    pipe_out_rdy = 1'b1;
    wait_done(50);
    abort_i = 1'b0;
    chk_seq("abort_stall", 7, 1, 1);
    chk("abort_stall_flag", int'(aborted_o), 1);
    chk("abort_stall_sent", int'(sent_count_o), 1);

    go(3, 1, 1, 3);
    @(posedge clk_i); #1;
    abort_i = 1'b1;
    wait_done(50);
    abort_i = 1'b0;
    chk_seq("abort_gap", 1, 1, 1);
    chk("abort_gap_flag", int'(aborted_o), 1);

    abort_i = 1'b1;
    go(1, 5, 1, 0);
    wait_done(50);
    abort_i = 1'b0;
    chk("final_abort_flag", int'(aborted_o), 0);
    chk("final_abort_sent", int'(sent_count_o), 1);

    go(0, 9, 1, 0);
    wait_done(20);
    chk("zero_len", log_q.size(), 0);
    chk("zero_done_lat", done_cyc - start_cyc, 1);

    go(4, 2, 3, 2);
    repeat (2) begin @(posedge clk_i); #1; end
    num_items_i = 8'd9;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(100);
    chk_seq("busy_start", 2, 3, 4);
    chk("busy_start_sent", int'(sent_count_o), 4);

    go(255, 0, 1, 0);
    wait_done(400);
    chk("max_len", log_q.size(), 255);
    chk("max_last", int'(log_q.size() == 255 ? log_q[254] : '0), 30);
    chk("max_sent", int'(sent_count_o), 255);

    for (int r = 0; r < 40; r++) begin
      int num, sv, st, g, k;
      num = $urandom_range(0, 12);
      sv  = $urandom_range(0, VMASK);
      st  = $urandom_range(0, VMASK);
      g   = $urandom_range(0, 3);
      go(num, sv, st, g);
      k = 0;
      while (done_cnt == base_done && k < 500) begin
        pipe_out_rdy = ($urandom_range(0, 3) != 0);
        abort_i      = ($urandom_range(0, 40) == 0);
        @(posedge clk_i); #1;
        k++;
      end
      abort_i = 1'b0;
      pipe_out_rdy = 1'b1;
      chk("rand_done_seen", done_cnt - base_done, 1);
      for (int i = 0; i < log_q.size(); i++)
        chk("rand_beat", int'(log_q[i]), (sv + i * st) & VMASK);
    end

    pipe_out_rdy = 1'b0;
    go(10, 4, 1, 0);
    repeat (2) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    chk("mid_rst_valid", int'(pipe_out_valid), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    chk("mid_rst_sent", int'(sent_count_o), 0);
    chk("mid_rst_val", int'(output_val), 0);
    chk("mid_rst_aborted", int'(aborted_o), 0);
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    pipe_out_rdy = 1'b1;
    go(2, 20, 7, 1);
    wait_done(50);
    chk_seq("post_rst", 20, 7, 2);

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
